// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: per-channel divided clock and one-cycle tick (CLK_DIV_DUTY_EN adds cfg_high duty control).
// Latency: outputs registered, 1 clk after enable/sync; backpressure: cfg_ready low while a channel already holds a pending ratio.
module clk_div_gen #(
    parameter int NUM_CH  = 3,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [DIV_W-1:0]  cfg_high,
`endif
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO  = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEFD = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0]  d_act    [NUM_CH];
    logic [DIV_W-1:0]  cnt      [NUM_CH];
    logic [DIV_W-1:0]  pend_div [NUM_CH];
    logic [NUM_CH-1:0] pend_vld;

    logic [DIV_W-1:0]  d_nxt    [NUM_CH];
    logic [DIV_W-1:0]  cnt_nxt  [NUM_CH];
    logic [DIV_W-1:0]  pd_nxt   [NUM_CH];
    logic [DIV_W-1:0]  h_use    [NUM_CH];
    logic [NUM_CH-1:0] pv_nxt;
    logic [NUM_CH-1:0] co_nxt;
    logic [NUM_CH-1:0] tk_nxt;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] apply;

`ifdef CLK_DIV_DUTY_EN
    logic [DIV_W-1:0]  h_act     [NUM_CH];
    logic [DIV_W-1:0]  pend_high [NUM_CH];
    logic [DIV_W-1:0]  h_nxt     [NUM_CH];
    logic [DIV_W-1:0]  ph_nxt    [NUM_CH];
`endif

    logic ch_ok;
    logic acc;
    logic bad;
    logic wr;

    // Out-of-range channels report ready so the write is taken and flagged as an error.
    assign ch_ok     = (int'(cfg_ch) < NUM_CH);
    assign cfg_ready = ch_ok ? !pend_vld[cfg_ch] : 1'b1;
    assign acc       = cfg_valid && cfg_ready;
    assign bad       = (cfg_div < TWO) || !ch_ok;
    assign wr        = acc && !bad;

    always_comb begin
        wrap  = '0;
        apply = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            d_nxt[i]   = d_act[i];
            cnt_nxt[i] = cnt[i];
            pd_nxt[i]  = pend_div[i];
            pv_nxt[i]  = pend_vld[i];
            co_nxt[i]  = 1'b0;
            tk_nxt[i]  = 1'b0;
`ifdef CLK_DIV_DUTY_EN
            h_nxt[i]   = h_act[i];
            ph_nxt[i]  = pend_high[i];
`endif
            wrap[i]  = (cnt[i] == d_act[i] - ONE);
            // Pending ratios land only on a period boundary: disable, sync or wrap.
            apply[i] = pend_vld[i] && (!ch_en[i] || sync || wrap[i]);
            if (apply[i]) begin
                d_nxt[i]  = pend_div[i];
                pv_nxt[i] = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                h_nxt[i]  = pend_high[i];
`endif
            end

            if (!ch_en[i]) begin
                cnt_nxt[i] = d_nxt[i] - ONE;
            end else if (sync || wrap[i]) begin
                cnt_nxt[i] = '0;
            end else begin
                cnt_nxt[i] = cnt[i] + ONE;
            end

`ifdef CLK_DIV_DUTY_EN
            h_use[i] = h_nxt[i];
`else
            h_use[i] = d_nxt[i] >> 1;
`endif
            if (ch_en[i]) begin
                co_nxt[i] = (cnt_nxt[i] < h_use[i]);
                tk_nxt[i] = (cnt_nxt[i] == d_nxt[i] - ONE);
            end

            if (wr && (int'(cfg_ch) == i)) begin
                pv_nxt[i] = 1'b1;
                pd_nxt[i] = cfg_div;
`ifdef CLK_DIV_DUTY_EN
                ph_nxt[i] = cfg_high;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_act[i]    <= DEFD;
                cnt[i]      <= DEFD - ONE;
                pend_div[i] <= DEFD;
`ifdef CLK_DIV_DUTY_EN
                h_act[i]     <= DEFD >> 1;
                pend_high[i] <= DEFD >> 1;
`endif
            end
            pend_vld <= '0;
            clk_out  <= '0;
            tick     <= '0;
            cfg_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                d_act[i]    <= d_nxt[i];
                cnt[i]      <= cnt_nxt[i];
                pend_div[i] <= pd_nxt[i];
`ifdef CLK_DIV_DUTY_EN
                h_act[i]     <= h_nxt[i];
                pend_high[i] <= ph_nxt[i];
`endif
            end
            pend_vld <= pv_nxt;
            clk_out  <= co_nxt;
            tick     <= tk_nxt;
            cfg_err  <= acc && bad;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: ratios, sync, config handshake/errors, disable, reset and optional duty control.
module tb_clk_div_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ch_en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
`ifdef CLK_DIV_DUTY_EN
    logic [7:0] cfg_high;
`endif
    logic       cfg_err;
    logic [2:0] clk_out;
    logic [2:0] tick;

    int tests  = 0;
    int failed = 0;

    logic [2:0] e2c [8];
    logic [2:0] e2t [8];
    logic       e3c [7];
    logic       e3t [7];

    always #5 clk = ~clk;

    clk_div_gen #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLK_DIV_DUTY_EN
        .cfg_high  (cfg_high),
`endif
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        e2c = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001, 3'b000};
        e2t = '{3'b000, 3'b001, 3'b000, 3'b011, 3'b000, 3'b001, 3'b000, 3'b111};
        e3c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e3t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; ch_en = 3'b000; sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
`ifdef CLK_DIV_DUTY_EN
        cfg_high = 8'd0;
`endif
        cyc(); cyc();
        chk("rst_clk_out", 32'(clk_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'h1);

        // Default D=2 on all channels, in phase from one cycle after enable
        rst = 1'b0; ch_en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("d2_clk_%0d", k), 32'(clk_out), (k % 2 == 0) ? 32'h7 : 32'h0);
            chk($sformatf("d2_tick_%0d", k), 32'(tick), (k % 2 == 0) ? 32'h0 : 32'h7);
        end

        // ch1 D=4, ch2 D=8, then sync
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
        cyc();
        cfg_ch = 2'd2; cfg_div = 8'd8;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        cyc();
        sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            chk($sformatf("mix_clk_%0d", k), 32'(clk_out), 32'(e2c[k]));
            chk($sformatf("mix_tick_%0d", k), 32'(tick), 32'(e2t[k]));
        end

        // ch0 D=4, write D=6 at cnt=1, second write D=3 stalls until the wrap
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("chg_s0_clk", 32'(clk_out[0]), 32'h1);
        cyc();
        chk("chg_s1_clk", 32'(clk_out[0]), 32'h1);
        chk("chg_s1_tick", 32'(tick[0]), 32'h0);
        cfg_valid = 1'b1; cfg_div = 8'd6;
        cyc();
        chk("chg_s2_clk", 32'(clk_out[0]), 32'h0);
        chk("chg_s2_ready", 32'(cfg_ready), 32'h0);
        cfg_div = 8'd3;
        cyc();
        chk("chg_s3_clk", 32'(clk_out[0]), 32'h0);
        chk("chg_s3_tick", 32'(tick[0]), 32'h1);
        chk("chg_s3_ready", 32'(cfg_ready), 32'h0);
        cyc();
        chk("chg_s4_clk", 32'(clk_out[0]), 32'h1);
        chk("chg_s4_tick", 32'(tick[0]), 32'h0);
        chk("chg_s4_ready", 32'(cfg_ready), 32'h1);
        cyc();
        cfg_valid = 1'b0;
        chk("chg_s5_clk", 32'(clk_out[0]), 32'h1);
        chk("chg_s5_ready", 32'(cfg_ready), 32'h0);
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk($sformatf("chg_s%0d_clk", k + 6), 32'(clk_out[0]), 32'(e3c[k]));
            chk($sformatf("chg_s%0d_tick", k + 6), 32'(tick[0]), 32'(e3t[k]));
        end

        // Rejected writes: D=1, D=0, channel 3
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        cyc();
        chk("err_div1", 32'(cfg_err), 32'h1);
        cfg_div = 8'd0;
        cyc();
        chk("err_div0", 32'(cfg_err), 32'h1);
        cfg_ch = 2'd3; cfg_div = 8'd5;
        chk("err_ch3_ready", 32'(cfg_ready), 32'h1);
        cyc();
        chk("err_ch3", 32'(cfg_err), 32'h1);
        cfg_valid = 1'b0; cfg_ch = 2'd0;
        cyc();
        chk("err_clear", 32'(cfg_err), 32'h0);
        chk("err_ready_ch0", 32'(cfg_ready), 32'h1);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("err_keep_clk0", 32'(clk_out), 32'h7);
        chk("err_keep_tick0", 32'(tick), 32'h0);
        cyc();
        chk("err_keep_clk1", 32'(clk_out), 32'h6);
        chk("err_keep_tick1", 32'(tick), 32'h0);
        cyc();
        chk("err_keep_clk2", 32'(clk_out), 32'h4);
        chk("err_keep_tick2", 32'(tick), 32'h1);

        // Disable ch1, write D=3, re-enable
        ch_en = 3'b101;
        cyc();
        chk("dis_clk", 32'(clk_out[1]), 32'h0);
        chk("dis_tick", 32'(tick[1]), 32'h0);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        chk("dis_wr_clk", 32'(clk_out[1]), 32'h0);
        cyc();
        chk("dis_apply_clk", 32'(clk_out[1]), 32'h0);
        chk("dis_apply_ready", 32'(cfg_ready), 32'h1);
        ch_en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("ren_clk_%0d", k), 32'(clk_out[1]), (k % 3 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("ren_tick_%0d", k), 32'(tick[1]), (k % 3 == 2) ? 32'h1 : 32'h0);
        end

`ifdef CLK_DIV_DUTY_EN
        // D=5 with high time 1, 5 and 0
        for (int h = 0; h < 3; h++) begin
            cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
            cfg_high = (h == 0) ? 8'd1 : ((h == 1) ? 8'd5 : 8'd0);
            cyc();
            cfg_valid = 1'b0; sync = 1'b1;
            cyc();
            sync = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) cyc();
                chk($sformatf("duty%0d_clk_%0d", h, k), 32'(clk_out[0]),
                    (h == 1) ? 32'h1 : ((h == 0 && k == 0) ? 32'h1 : 32'h0));
                chk($sformatf("duty%0d_tick_%0d", h, k), 32'(tick[0]), (k == 4) ? 32'h1 : 32'h0);
            end
        end
`endif

        // Reset mid-run drops a pending write
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd5;
        cyc();
        cfg_valid = 1'b0;
        chk("prst_ready", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        cyc();
        chk("mrst_clk", 32'(clk_out), 32'h0);
        chk("mrst_tick", 32'(tick), 32'h0);
        chk("mrst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        cyc();
        chk("arst_clk0", 32'(clk_out), 32'h7);
        chk("arst_tick0", 32'(tick), 32'h0);
        cyc();
        chk("arst_clk1", 32'(clk_out), 32'h0);
        chk("arst_tick1", 32'(tick), 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesisable, parametrised multi-channel clock-enable/divided-clock generator driven from the single system clock.
- Replaces fixed-rate toggling clocks (100/50/25 MHz style) with runtime-programmable integer dividers.
- Each channel produces a registered divided clock-like output and a one-cycle tick enable.
- Used by downstream logic as clock enables, or by benches as derived clocks.

Parameters:
- NUM_CH, 3, number of independent divider channels (>=1).
- DIV_W, 8, width of divide ratio and counters.
- DEF_DIV, 2, reset divide ratio for all channels (must be >=2 and <2^DIV_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle pulse; phase-restarts all enabled channels.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted for cfg_ch.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  DIV_W  new divide ratio D (period in clk cycles).
- cfg_err  out  1  one-cycle pulse: write rejected.
- clk_out  out  NUM_CH  divided output per channel, registered.
- tick  out  NUM_CH  one-cycle pulse per period, registered.

Behaviour:
- Per channel state: D_act (active ratio), cnt (0..D_act-1), pend_vld, pend_div.
- H = D_act>>1 (high time). Registered outputs track the post-edge cnt: clk_out = (cnt < H), tick = (cnt == D_act-1).
- Resulting waveforms:
  - D=2: clk_out 1,0,1,0; tick 0,1,0,1.
  - D=3: clk_out 1,0,0; tick on the third cycle.
- Reset: D_act=DEF_DIV, cnt=DEF_DIV-1, pend_vld=0, clk_out=0, tick=0, cfg_err=0. cfg_ready=1 after reset.
- Priority per edge: rst > ch_en low > sync > normal count.
- Disabled (ch_en[i]=0):
  - cnt held at D_act-1; clk_out=0; tick=0.
  - A pending config applies immediately (D_act<=pend_div, cnt<=pend_div-1, pend_vld<=0).
- First enabled edge: cnt wraps to 0, so clk_out goes 1 the cycle after ch_en rises. Latency is 1 clk.
- Normal: cnt<=(cnt==D_act-1)?0:cnt+1.
- Wrap edge (cnt==D_act-1): if pend_vld, D_act<=pend_div and pend_vld<=0. Ratio changes only at period boundaries, so no runt pulses.
- sync: every enabled channel loads cnt<=0 (clk_out=1, tick=0 next cycle) and applies any pending config first. Disabled channels ignore sync.
- Config handshake:
  - cfg_ready = !pend_vld[cfg_ch] (combinational).
  - Transfer occurs on cfg_valid && cfg_ready.
  - If cfg_div<2 or cfg_ch>=NUM_CH: no state change; cfg_err pulses high the next cycle.
  - Otherwise pend_div<=cfg_div and pend_vld<=1.
  - cfg_valid with ready low stalls; the requester holds its inputs.
- Same-edge accept and wrap on the same channel: the new value is latched as pending and applied at the following wrap. The old pending value was already applied at this edge.
- rst mid-period: all channels return to the reset state on that edge; any pending write is lost.
- Counter widths are DIV_W; D_act max = 2^DIV_W-1. No overflow occurs because cnt<D_act.

Optional Feature:
- Macro CLK_DIV_DUTY_EN.
- When defined:
  - Extra input cfg_high (DIV_W), captured with cfg_div into pend_high and applied together as H_act.
  - clk_out = (cnt < H_act). H_act=0 gives constant 0; H_act>=D_act gives constant 1; tick is unaffected.
  - Reset H_act = DEF_DIV>>1.
- When undefined: cfg_high port is absent and H = D_act>>1.

Test Plan:
- Reset, then ch_en=3'b111 with default D=2 -> all clk_out toggle 1,0,1,0 from 1 cycle after enable; tick high on every second cycle; all channels in phase.
- Write ch1 D=4 and ch2 D=8, then pulse sync -> ch0 period 2, ch1 period 4 (1,1,0,0), ch2 period 8 (four 1s, four 0s); all clk_out rise on the cycle after sync.
- ch0 running D=4; write D=6 when cnt=1 -> current period completes 4 cycles, next period 6 cycles; second write held off (cfg_ready=0) until the wrap.
- Write cfg_div=1, then cfg_div=0, then cfg_ch=3 -> three cfg_err pulses; D_act and outputs unchanged.
- Disable ch1 mid-period, write D=3, re-enable -> clk_out/tick 0 while disabled; after enable the period is 3 (1,0,0) starting at cnt=0.
- CLK_DIV_DUTY_EN: D=5, cfg_high=1 -> clk_out 1,0,0,0,0; cfg_high=5 -> constant 1; cfg_high=0 -> constant 0; tick every 5 cycles in all cases.
